lc3_fetch: RTL

//  LC-3 instruction fetch stage: owns PC, issues one memory read per fetch command,

---
 rtl/lc3_pkg.sv | 13 +
 rtl/adder_16.sv | 10 +
 rtl/lc3_fetch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants and the fetch-stage state encoding.
package lc3_pkg;

  localparam int          WORD_W       = 16;
  localparam logic [15:0] LC3_RESET_PC = 16'h3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_FAULT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/adder_16.sv
// 16-bit modulo-2^16 adder shared by the LC-3 datapath (PC+1, PC+offset).
module adder_16 (
  input  logic [15:0] in_a_i,
  input  logic [15:0] in_b_i,
  output logic [15:0] sum_o
);

  assign sum_o = in_a_i + in_b_i;

endmodule

// File: rtl/lc3_fetch.sv
// LC-3 instruction fetch stage: owns PC, issues one memory read per fetch, captures IR.
// Optional build macro LC3_FETCH_STALL_CNT_EN adds a saturating stall_cnt_o output.
module lc3_fetch
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = LC3_RESET_PC,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_go_i,
  input  logic              pc_ld_i,
  input  logic              pc_src_i,
  input  logic [WORD_W-1:0] addr_sum_i,
  input  logic [WORD_W-1:0] bus_in_i,
  output logic              mem_req_o,
  output logic [WORD_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic [WORD_W-1:0] ir_o,
  output logic              ir_valid_o,
  output logic [WORD_W-1:0] pc_o,
  output logic              busy_o,
  output logic              fault_o
`ifdef LC3_FETCH_STALL_CNT_EN
  ,output logic [31:0]      stall_cnt_o
`endif
);

  // Counter value on the last permitted wait cycle; one more miss means fault.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic              fault_q, fault_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0] pc_inc_s;

  adder_16 u_pc_inc (
    .in_a_i (pc_q),
    .in_b_i (16'h0001),
    .sum_o  (pc_inc_s)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        cnt_d     = 16'd0;
        if (pc_ld_i) begin
          pc_d = pc_src_i ? bus_in_i : addr_sum_i;
        end else begin
          pc_d = pc_q;
        end
        // A same-cycle PC load feeds the address of the fetch it launches.
        if (fetch_go_i) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          ir_d       = mem_rdata_i;
          pc_d       = pc_inc_s;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          cnt_d      = 16'd0;
          state_d    = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          state_d   = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_FAULT: begin
        mem_req_d = 1'b0;
        fault_d   = 1'b1;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 16'h0000;
      fault_q    <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign busy_o     = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign pc_o       = pc_q;
  assign fault_o    = fault_q;

`ifdef LC3_FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_REQ) && !mem_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
